// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port: one outstanding
// request, configurable access latency, RV32I store byte-lane masking and
// right-justified (unextended) load data.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        commit;

    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    // With LATENCY==1 the commit edge is also the accept edge, so the access
    // has to be decoded from the live request rather than the latched copy.
    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    assign cur_write  = (state_q == IDLE) ? req_write  : write_q;
    assign cur_funct3 = (state_q == IDLE) ? req_funct3 : funct3_q;
    assign cur_addr   = (state_q == IDLE) ? req_addr   : addr_q;
    assign cur_wdata  = (state_q == IDLE) ? req_wdata  : wdata_q;

    logic             illegal, misalign, out_of_range, cur_err;
    logic [3:0]       byte_en;
    logic [31:0]      lane_data;
    logic [3:0]       lane_we;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0]      rd_word;

    // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        cnt_d   = 4'd0;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latency counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the request fields on acceptance; they stay frozen until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else if (state_q == IDLE && req_valid) begin
            write_q  <= req_write;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    // Decode access width into byte enables, replicated store data and error flags.
    always_comb begin
        illegal   = 1'b0;
        misalign  = 1'b0;
        byte_en   = 4'b0000;
        lane_data = cur_wdata;
        case (cur_funct3)
            3'b000: begin
                byte_en   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            3'b001: begin
                misalign  = cur_addr[0];
                byte_en   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            3'b010: begin
                misalign  = |cur_addr[1:0];
                byte_en   = 4'b1111;
            end
            3'b100:  illegal  = cur_write;
            3'b101: begin
                illegal  = cur_write;
                misalign = cur_addr[0];
            end
            default: illegal = 1'b1;
        endcase
        // Upper address bits are range-checked only, never dropped, so they cannot alias.
        out_of_range = (cur_addr[31:2] >= 30'(DEPTH));
        cur_err      = illegal | misalign | out_of_range;
    end

    assign mem_idx = cur_addr[IDX_W+1:2];
    assign lane_we = {4{commit & cur_write & ~cur_err}} & byte_en;

    // Error flag is decided at the commit edge and held through RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (commit) begin
            err_q <= cur_err;
        end
    end

    // One byte-wide RAM per lane: read-first, registered read, written only at commit.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // Commit-edge write of this lane and capture of its old contents.
        always_ff @(posedge clk) begin
            if (commit && !reset) begin
                if (lane_we[gi]) begin
                    mem[mem_idx] <= lane_data[8*gi +: 8];
                end
                rd_q <= mem[mem_idx];
            end
        end

        assign rd_word[8*gi +: 8] = rd_q;
    end

    // Right-justify the addressed lane; stores, errors and non-RESP cycles return zero.
    always_comb begin
        logic [31:0] load_data;
        load_data = 32'd0;
        case (funct3_q)
            3'b000, 3'b100: load_data = {24'd0, rd_word[8*addr_q[1:0] +: 8]};
            3'b001, 3'b101: load_data = {16'd0, (addr_q[1] ? rd_word[31:16] : rd_word[15:0])};
            3'b010:         load_data = rd_word;
            default:        load_data = 32'd0;
        endcase
        rsp_rdata = (rsp_valid && !err_q && !write_q) ? load_data : 32'd0;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 runs with LATENCY=1,
// instance 1 with LATENCY=3 for latency, backpressure and reset-abort cases.
module tb_dmem_responder;
    localparam int DEPTH = 1024;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;
    localparam logic [2:0] F_X  = 3'b011;

    logic        clk = 1'b0;
    logic        reset      [2];
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic        rsp_ready  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request/response. hold>0 keeps rsp_ready low for that many extra cycles.
    task automatic txn(input int d, input string name, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        check({name, ".req_ready"}, 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_write[d]  = wr;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        rsp_ready[d]  = (hold == 0);
        @(negedge clk);
        // Garbage request while busy: must be ignored (it would corrupt this word otherwise).
        req_write[d]  = ~wr;
        req_funct3[d] = F_W;
        req_addr[d]   = {addr[31:2], 2'b00};
        req_wdata[d]  = 32'hCAFEF00D;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, ".lat"}, 32'(lat), 32'(exp_lat));
        check({name, ".rdata"}, rsp_rdata[d], exp_rd);
        check({name, ".err"}, 32'(rsp_err[d]), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, ".hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            check({name, ".hold_rdata"}, rsp_rdata[d], exp_rd);
            check({name, ".hold_req_ready"}, 32'(req_ready[d]), 32'd0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        $display("txn lat%0d %-10s wr=%b f3=%b addr=%h wdata=%h -> rdata=%h err=%b cycles=%0d",
                 exp_lat, name, wr, f3, addr, wd, rsp_rdata[d], rsp_err[d], lat);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
            req_funct3[d] = 3'b000; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
            rsp_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        check("rst.req_ready", 32'(req_ready[0]), 32'd1);
        check("rst.rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst.rsp_err",   32'(rsp_err[0]),   32'd0);
        check("rst.rsp_rdata", rsp_rdata[0],      32'd0);
        check("rst.l3_valid",  32'(rsp_valid[1]), 32'd0);

        // LATENCY=1: store/load, byte and half merges, loads of every width.
        txn(0, "sw10",   1'b1, F_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0);
        txn(0, "lw10a",  1'b0, F_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0);
        txn(0, "sb11",   1'b1, F_B,  32'h11, 32'h000000AA, 32'h0,        1'b0, 0);
        txn(0, "lw10b",  1'b0, F_W,  32'h10, 32'h0,        32'hDEADAAEF, 1'b0, 0);
        txn(0, "lbu11",  1'b0, F_BU, 32'h11, 32'h0,        32'h000000AA, 1'b0, 0);
        txn(0, "lb13",   1'b0, F_B,  32'h13, 32'h0,        32'h000000DE, 1'b0, 0);
        txn(0, "sh12",   1'b1, F_H,  32'h12, 32'h00001234, 32'h0,        1'b0, 0);
        txn(0, "lw10c",  1'b0, F_W,  32'h10, 32'h0,        32'h1234AAEF, 1'b0, 0);
        txn(0, "lhu12",  1'b0, F_HU, 32'h12, 32'h0,        32'h00001234, 1'b0, 0);
        txn(0, "lh10",   1'b0, F_H,  32'h10, 32'h0,        32'h0000AAEF, 1'b0, 0);

        // Errors: misaligned, out of range, aliasing high bits, illegal funct3.
        txn(0, "lw13",   1'b0, F_W,  32'h13, 32'h0,        32'h0,        1'b1, 0);
        txn(0, "sh11",   1'b1, F_H,  32'h11, 32'h0000FFFF, 32'h0,        1'b1, 0);
        txn(0, "sbu10",  1'b1, F_BU, 32'h10, 32'h000000FF, 32'h0,        1'b1, 0);
        txn(0, "lx10",   1'b0, F_X,  32'h10, 32'h0,        32'h0,        1'b1, 0);
        txn(0, "lw_oor", 1'b0, F_W,  32'(4*DEPTH), 32'h0,  32'h0,        1'b1, 0);
        txn(0, "sw_alias", 1'b1, F_W, 32'h80000010, 32'h0BADBAD0, 32'h0, 1'b1, 0);
        txn(0, "lw10d",  1'b0, F_W,  32'h10, 32'h0,        32'h1234AAEF, 1'b0, 0);

        // Last word of the array.
        txn(0, "swtop",  1'b1, F_W,  32'(4*DEPTH-4), 32'h0, 32'h0,       1'b0, 0);
        txn(0, "sbtop",  1'b1, F_B,  32'(4*DEPTH-1), 32'h77, 32'h0,      1'b0, 0);
        txn(0, "lwtop",  1'b0, F_W,  32'(4*DEPTH-4), 32'h0, 32'h77000000, 1'b0, 0);

        // LATENCY=3: latency and 4 cycles of response backpressure.
        txn(1, "sw20",   1'b1, F_W,  32'h20, 32'h11111111, 32'h0,        1'b0, 0);
        txn(1, "lw20bp", 1'b0, F_W,  32'h20, 32'h0,        32'h11111111, 1'b0, 4);
        @(negedge clk);
        check("bp.req_ready_after", 32'(req_ready[1]), 32'd1);
        check("bp.rsp_valid_after", 32'(rsp_valid[1]), 32'd0);

        // Reset one cycle after accepting a store: store is dropped, no response.
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_funct3[1] = F_W;
        req_addr[1] = 32'h20; req_wdata[1] = 32'h55;
        @(negedge clk);
        req_valid[1] = 1'b0;
        reset[1] = 1'b1;
        @(negedge clk);
        reset[1] = 1'b0;
        check("rstmid.req_ready", 32'(req_ready[1]), 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[1]) seen++;
        end
        check("rstmid.no_rsp", 32'(seen), 32'd0);
        $display("txn lat3 rstmid     SW 0x20 0x55 aborted by reset, responses seen=%0d", seen);
        @(posedge clk);
        txn(1, "lw20post", 1'b0, F_W, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's load/store interface.
- Accepts one request at a time and applies RISC-V store byte/half/word masking.
- For loads, returns the addressed lane right-justified; the core's load extension logic then sign- or zero-extends it per funct3.
- Models configurable access latency with a valid/ready request channel and a valid/ready response channel. This lets the core and test benches exercise stalls.

Parameters:
- DEPTH, 1024, number of 32-bit words (power of two, ≥4).
- LATENCY, 1, cycles from request acceptance to first rsp_valid (≥1, ≤15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I load/store funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; lane taken from the low bits.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  core accepts the response.
- rsp_rdata  output  32  load data, right-justified and zero-filled above the access width; 0 for stores and errors.
- rsp_err  output  1  misaligned access, out-of-range address, or illegal funct3.

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE, counter to 0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory contents are not cleared.
  - A reset mid-transaction aborts it. A pending store not yet committed is dropped.
- FSM states IDLE, WAIT, RESP:
  - IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata.
    - If LATENCY==1, go to RESP.
    - Otherwise go to WAIT with counter=LATENCY-1.
  - WAIT: req_ready=0. Decrement the counter each cycle. When it reaches 1, go to RESP on the next edge.
  - RESP: rsp_valid=1, req_ready=0. Hold rsp_rdata and rsp_err stable until rsp_valid&&rsp_ready, then return to IDLE.
  - No request is accepted in the RESP cycle itself. Back-to-back throughput is therefore one request per LATENCY+1 cycles when rsp_ready is tied high.
- Commit point: the memory read and write both happen on the edge that enters RESP.
  - Stores write the array on that edge.
  - Loads capture the word on that edge.
  - A load accepted after a store's response always sees the stored data.
- Error checks, evaluated on latched request fields:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - Word index addr[31:2] ≥ DEPTH is out of range.
  - funct3 in {011, 110, 111}, or a store with funct3 in {100, 101}, is illegal.
  - On any error: no memory write, rsp_err=1, rsp_rdata=0.
- Store masking (word index = addr[2+log2(DEPTH)-1:2]):
  - SB: write byte lane addr[1:0] with wdata[7:0].
  - SH: write half lane addr[1] with wdata[15:0].
  - SW: write the full word.
  - Unselected bytes are unchanged.
- Load data:
  - B/BU: rdata = {24'b0, byte at addr[1:0]}.
  - H/HU: rdata = {16'b0, half at addr[1]}.
  - W: the full word.
  - Extension is not performed here.
- Stores respond with rsp_rdata=0.
- Signals ignored outside IDLE: req_valid is ignored in WAIT and RESP, and req fields may change freely there.
- Address bits above the index range are checked for out-of-range only. They never alias to a valid word.

Test Plan:
- Reset then idle, LATENCY=1 → req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → rsp_valid on the cycle after acceptance for each; load rdata=0xDEADBEEF, rsp_err=0.
- Byte merge on word 0x10 (holding 0xDEADBEEF):
  - SB addr 0x11 wdata 0x000000AA, then LW 0x10 → 0xDEADAABF? No: the byte at lane 1 becomes AA, so the word reads 0xDEADAAEF.
  - LBU 0x11 → 0x000000AA.
  - SH 0x12 wdata 0x1234, then LW 0x10 → 0x1234AAEF.
- Errors:
  - LW addr 0x13 → rsp_err=1, rsp_rdata=0.
  - SH addr 0x11 wdata 0xFFFF → rsp_err=1, and a subsequent LW 0x10 still returns 0x1234AAEF.
  - LW addr 4*DEPTH → rsp_err=1.
- Latency and backpressure, LATENCY=3:
  - Request accepted at cycle 0 → rsp_valid first high at cycle 3.
  - Hold rsp_ready=0 for 4 cycles → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout.
  - Raise rsp_ready → req_ready=1 on the next cycle.
- Reset mid-operation, LATENCY=3: issue SW 0x20 data 0x55, assert reset at cycle 1 → rsp_valid never rises and req_ready=1 after reset; a following LW 0x20 does not return 0x55 (the initial contents are unchanged).
